// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the iterative AES-128 round controller.
package aes_ctrl_pkg;

  localparam int unsigned AES_STATE_W   = 128;
  localparam int unsigned AES128_ROUNDS = 10;
  localparam int unsigned ROUND_IDX_W   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRound,
    StDone
  } aes_ctrl_st_e;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Block I/O, round-datapath strobes and status of the AES round controller.
// master: wrapper/datapath side; slave: the controller.
interface aes_round_ctrl_if
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned StateW = AES_STATE_W
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [StateW-1:0]      in_state;
  logic [StateW-1:0]      in_key;
  logic                   dp_load;
  logic                   dp_round_en;
  logic                   dp_last;
  logic [ROUND_IDX_W-1:0] dp_round;
  logic [StateW-1:0]      dp_pt;
  logic [StateW-1:0]      dp_key;
  logic [StateW-1:0]      dp_state;
  logic                   out_valid;
  logic                   out_ready;
  logic [StateW-1:0]      out_state;
  logic                   busy;

  modport master (
    output in_valid, in_state, in_key, out_ready, dp_state,
    input  in_ready, dp_load, dp_round_en, dp_last, dp_round, dp_pt, dp_key,
    input  out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, in_key, out_ready, dp_state,
    output in_ready, dp_load, dp_round_en, dp_last, dp_round, dp_pt, dp_key,
    output out_valid, out_state, busy
  );

endinterface

// File: rtl/aes_round_counter.sv
// Round index counter: loads to 1, increments, flags the terminal round.
module aes_round_counter #(
  parameter int unsigned Width     = 4,
  parameter int unsigned TermCount = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             incr_i,
  output logic [Width-1:0] cnt_o,
  output logic             term_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = Width'(1);
    end else if (incr_i) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == Width'(TermCount));

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for the iterative AES-128 round datapath (IDLE/LOAD/ROUND/DONE).
// Optional AES_PERF_CNT_EN adds a completed-block counter (blk_cnt) with clear (cnt_clr).
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES128_ROUNDS,
  parameter int unsigned STATE_W    = AES_STATE_W
) (
  input  logic        clk,
  input  logic        rst,
`ifdef AES_PERF_CNT_EN
  input  logic        cnt_clr,
  output logic [31:0] blk_cnt,
`endif
  aes_round_ctrl_if.slave bus
);

  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 15) begin : g_bad_rounds
    $fatal(1, "aes_round_ctrl: NUM_ROUNDS must be within 1..15");
  end

  aes_ctrl_st_e state_q, state_d;

  logic [ROUND_IDX_W-1:0] round_cnt;
  logic                   round_term;
  logic                   accept;
  logic                   out_hs;

  logic [STATE_W-1:0] dp_pt_q, dp_pt_d;
  logic [STATE_W-1:0] dp_key_q, dp_key_d;
  logic [STATE_W-1:0] out_state_q, out_state_d;
  logic               capt_q, capt_d;

  assign accept = (state_q == StIdle) && bus.in_valid;
  assign out_hs = (state_q == StDone) && bus.out_ready;

  aes_round_counter #(
    .Width     (ROUND_IDX_W),
    .TermCount (NUM_ROUNDS)
  ) u_round_counter (
    .clk    (clk),
    .rst    (rst),
    .load_i (state_q == StLoad),
    .incr_i (state_q == StRound),
    .cnt_o  (round_cnt),
    .term_o (round_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StLoad;
      StLoad:  state_d = StRound;
      StRound: if (round_term) state_d = StDone;
      StDone:  if (out_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.in_ready    = 1'b0;
    bus.dp_load     = 1'b0;
    bus.dp_round_en = 1'b0;
    bus.dp_last     = 1'b0;
    bus.dp_round    = '0;
    bus.out_valid   = 1'b0;
    unique case (state_q)
      StIdle:  bus.in_ready = 1'b1;
      StLoad:  bus.dp_load = 1'b1;
      StRound: begin
        bus.dp_round_en = 1'b1;
        bus.dp_round    = round_cnt;
        bus.dp_last     = round_term;
      end
      StDone:  bus.out_valid = 1'b1;
      default: ;
    endcase
    bus.busy = (state_q != StIdle);
  end

  // The last round lands in the datapath register on DONE entry, so the first DONE cycle
  // forwards dp_state directly and the capture register holds it from then on.
  always_comb begin
    dp_pt_d     = accept ? bus.in_state : dp_pt_q;
    dp_key_d    = accept ? bus.in_key : dp_key_q;
    out_state_d = out_state_q;
    if ((state_q == StDone) && !capt_q) begin
      out_state_d = bus.dp_state;
    end
    capt_d = (state_q == StDone) && !out_hs;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_pt_q     <= '0;
      dp_key_q    <= '0;
      out_state_q <= '0;
      capt_q      <= 1'b0;
    end else begin
      dp_pt_q     <= dp_pt_d;
      dp_key_q    <= dp_key_d;
      out_state_q <= out_state_d;
      capt_q      <= capt_d;
    end
  end

  assign bus.dp_pt     = dp_pt_q;
  assign bus.dp_key    = dp_key_q;
  assign bus.out_state = ((state_q == StDone) && !capt_q) ? bus.dp_state : out_state_q;

`ifdef AES_PERF_CNT_EN
  logic [31:0] blk_cnt_q, blk_cnt_d;

  always_comb begin
    blk_cnt_d = blk_cnt_q;
    if (cnt_clr) begin
      blk_cnt_d = '0;
    end else if (out_hs) begin
      blk_cnt_d = blk_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt_q <= '0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule
